// File: rtl/gcd_job_sequencer.sv
// Front-end job controller for the GCD engine: operand capture, Start/Ack/CEN
// handshake, run timing with timeout abort, result latch. Optional STEP_EN build
// makes CEN a registered copy of the Step pulse for single-stepping the engine.
module gcd_job_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Sw,
  input  logic        Load,
  input  logic        Go,
  input  logic        Clear,
  input  logic        Step,
  input  logic        q_I,
  input  logic        q_Done,
  input  logic [7:0]  AB_GCD,
  output logic [7:0]  Ain,
  output logic [7:0]  Bin,
  output logic        Start,
  output logic        Ack,
  output logic        CEN,
  output logic        GcdRst,
  output logic [7:0]  Result,
  output logic        ResultValid,
  output logic        Busy,
  output logic        Error,
  output logic [15:0] Cycles,
  output logic [6:0]  State
);

  typedef enum logic [7:0] {
    S_LOAD_A = 8'b0000_0001,
    S_LOAD_B = 8'b0000_0010,
    S_READY  = 8'b0000_0100,
    S_RUN    = 8'b0000_1000,
    S_ACK    = 8'b0001_0000,
    S_SHOW   = 8'b0010_0000,
    S_DRAIN  = 8'b0100_0000,
    S_ERR    = 8'b1000_0000
  } state_t;

  state_t st, nxt;
  logic   ld_a, ld_b, zero_cyc, cap_res, set_rv, clr_rv, abort;
  logic   cnt_en;

`ifdef STEP_EN
  logic cen_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cen_q <= 1'b0;
    else       cen_q <= Step;
  assign CEN = cen_q;
`else
  logic unused_step;
  assign unused_step = Step;
  assign CEN = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) st <= S_LOAD_A;
    else       st <= nxt;

  always_comb begin
    nxt      = st;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    zero_cyc = 1'b0;
    cap_res  = 1'b0;
    set_rv   = 1'b0;
    clr_rv   = 1'b0;
    abort    = 1'b0;
    if (Clear) begin
      nxt   = S_LOAD_A;
      abort = (st == S_RUN);
    end else begin
      case (st)
        S_LOAD_A: if (Load) begin ld_a = 1'b1; clr_rv = 1'b1; nxt = S_LOAD_B; end
        S_LOAD_B: if (Load) begin ld_b = 1'b1; nxt = S_READY; end
        S_READY:
          if (Go) begin
            // a zero operand would never converge in the engine
            if (Ain == 8'd0 || Bin == 8'd0) nxt = S_ERR;
            else begin zero_cyc = 1'b1; nxt = S_RUN; end
          end
        S_RUN:
          if (q_Done) begin
            cap_res = 1'b1;
            nxt     = S_ACK;
          end else if (Cycles == TIMEOUT) begin
            abort = 1'b1;
            nxt   = S_ERR;
          end
        S_ACK: begin set_rv = 1'b1; nxt = S_SHOW; end
        S_SHOW:
          if (Go) begin
            zero_cyc = 1'b1;
            nxt      = S_RUN;
          end else if (Load) begin
            ld_a   = 1'b1;
            clr_rv = 1'b1;
            nxt    = S_LOAD_B;
          end
        S_DRAIN: nxt = S_ERR;
        S_ERR:   if (Load) begin ld_a = 1'b1; nxt = S_LOAD_B; end
        default: nxt = S_ERR;
      endcase
    end
  end

  // Count every enabled RUN cycle, including the one that samples q_Done.
  assign cnt_en = (st == S_RUN) && CEN && !abort && (Cycles != 16'hFFFF);

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Ain         <= 8'd0;
      Bin         <= 8'd0;
      Result      <= 8'd0;
      Cycles      <= 16'd0;
      ResultValid <= 1'b0;
      Ack         <= 1'b0;
      GcdRst      <= 1'b0;
    end else begin
      if (ld_a)    Ain    <= Sw;
      if (ld_b)    Bin    <= Sw;
      if (cap_res) Result <= AB_GCD;
      if (zero_cyc)    Cycles <= 16'd0;
      else if (cnt_en) Cycles <= Cycles + 16'd1;
      if (clr_rv)      ResultValid <= 1'b0;
      else if (set_rv) ResultValid <= 1'b1;
      Ack    <= (nxt == S_ACK);
      GcdRst <= abort;
    end

  assign Start = (st == S_RUN) && q_I;
  assign Busy  = (st == S_RUN) || (st == S_ACK) || (st == S_DRAIN);
  assign Error = (st == S_ERR);
  assign State = {st[7], st[6], st[5], st[4], st[3], st[2], st[0]};

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer: a subtractive GCD engine model drives the
// main instance; a second instance with TIMEOUT=20 sees an engine that never finishes.
module tb_gcd_job_sequencer;

  localparam logic [6:0] ST_LOAD_A = 7'b0000001;
  localparam logic [6:0] ST_LOAD_B = 7'b0000000;
  localparam logic [6:0] ST_RUN    = 7'b0000100;
  localparam logic [6:0] ST_SHOW   = 7'b0010000;
  localparam logic [6:0] ST_ERR    = 7'b1000000;
`ifdef STEP_EN
  localparam logic STEP_IDLE = 1'b1;
  localparam logic CEN_RST   = 1'b0;
`else
  localparam logic STEP_IDLE = 1'b0;
  localparam logic CEN_RST   = 1'b1;
`endif

  logic Clk = 1'b0;
  logic Reset, Load, Go, Clear, Step;
  logic [7:0] Sw;

  logic q_I, q_Done;
  logic [7:0] AB_GCD;
  logic [7:0] Ain, Bin, Result;
  logic Start, Ack, CEN, GcdRst, ResultValid, Busy, Error;
  logic [15:0] Cycles;
  logic [6:0] State;

  logic t_q_I;
  logic t_q_Done = 1'b0;
  logic [7:0] t_AB = 8'd0;
  logic [7:0] t_Ain, t_Bin, t_Result;
  logic t_Start, t_Ack, t_CEN, t_GcdRst, t_ResultValid, t_Busy, t_Error;
  logic [15:0] t_Cycles;
  logic [6:0] t_State;

  int n_vec = 0, n_bad = 0;
  int start_cnt = 0, ack_cnt = 0, rst_cnt = 0, t_rst_cnt = 0;

  always #5 Clk = ~Clk;

  gcd_job_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Sw(Sw), .Load(Load), .Go(Go), .Clear(Clear), .Step(Step),
    .q_I(q_I), .q_Done(q_Done), .AB_GCD(AB_GCD), .Ain(Ain), .Bin(Bin), .Start(Start),
    .Ack(Ack), .CEN(CEN), .GcdRst(GcdRst), .Result(Result), .ResultValid(ResultValid),
    .Busy(Busy), .Error(Error), .Cycles(Cycles), .State(State)
  );

  gcd_job_sequencer #(.TIMEOUT(16'd20)) dut_to (
    .Clk(Clk), .Reset(Reset), .Sw(Sw), .Load(Load), .Go(Go), .Clear(Clear), .Step(Step),
    .q_I(t_q_I), .q_Done(t_q_Done), .AB_GCD(t_AB), .Ain(t_Ain), .Bin(t_Bin), .Start(t_Start),
    .Ack(t_Ack), .CEN(t_CEN), .GcdRst(t_GcdRst), .Result(t_Result), .ResultValid(t_ResultValid),
    .Busy(t_Busy), .Error(t_Error), .Cycles(t_Cycles), .State(t_State)
  );

  // Subtractive GCD engine, clock-enabled by CEN; Ack and GcdRst act regardless.
  typedef enum logic [1:0] {E_I, E_SUB, E_DONE} est_t;
  est_t e_st;
  logic [7:0] ea, eb;
  always @(posedge Clk or posedge Reset)
    if (Reset) begin
      e_st <= E_I; ea <= 8'd0; eb <= 8'd0;
    end else if (GcdRst) e_st <= E_I;
    else if (e_st == E_DONE) begin
      if (Ack) e_st <= E_I;
    end else if (CEN) begin
      if (e_st == E_I) begin
        if (Start) begin ea <= Ain; eb <= Bin; e_st <= E_SUB; end
      end else if (ea == eb) e_st <= E_DONE;
      else if (ea > eb) ea <= ea - eb;
      else eb <= eb - ea;
    end
  assign q_I    = (e_st == E_I);
  assign q_Done = (e_st == E_DONE);
  assign AB_GCD = ea;

  // Hung engine: leaves I on Start, never reports done.
  always @(posedge Clk or posedge Reset)
    if (Reset)         t_q_I <= 1'b1;
    else if (t_GcdRst) t_q_I <= 1'b1;
    else if (t_Start)  t_q_I <= 1'b0;

  always @(negedge Clk) begin
    if (Start)    start_cnt++;
    if (Ack)      ack_cnt++;
    if (GcdRst)   rst_cnt++;
    if (t_GcdRst) t_rst_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic ld(input logic [7:0] v);
    Sw = v; Load = 1'b1; tick(); Load = 1'b0;
  endtask

  task automatic go();
    Go = 1'b1; tick(); Go = 1'b0;
  endtask

  task automatic clr();
    Clear = 1'b1; tick(); Clear = 1'b0;
  endtask

  task automatic wait_state(input logic [6:0] s, input int lim, input string tag);
    for (int i = 0; i < lim && State != s; i++) tick();
    chk(tag, {25'd0, State}, {25'd0, s});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, a0, r0, steps;
    Reset = 1'b1; Sw = 8'd0; Load = 1'b0; Go = 1'b0; Clear = 1'b0; Step = STEP_IDLE;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_state", {25'd0, State}, {25'd0, ST_LOAD_A});
    chk("rst_ain", {24'd0, Ain}, 0);
    chk("rst_bin", {24'd0, Bin}, 0);
    chk("rst_result", {24'd0, Result}, 0);
    chk("rst_cycles", {16'd0, Cycles}, 0);
    chk("rst_ack", {31'd0, Ack}, 0);
    chk("rst_gcdrst", {31'd0, GcdRst}, 0);
    chk("rst_rv", {31'd0, ResultValid}, 0);
    chk("rst_error", {31'd0, Error}, 0);
    chk("rst_start", {31'd0, Start}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_cen", {31'd0, CEN}, {31'd0, CEN_RST});
    Reset = 1'b0;
    tick();

    // 12,18 -> 6; one start + 2 subtracts + equal detect + done sample = 5 cycles
    clr(); ld(8'd12); ld(8'd18);
    s0 = start_cnt; a0 = ack_cnt;
    go();
    chk("t1_run", {25'd0, State}, {25'd0, ST_RUN});
    chk("t1_busy", {31'd0, Busy}, 1);
    wait_state(ST_SHOW, 50, "t1_show");
    chk("t1_result", {24'd0, Result}, 6);
    chk("t1_rv", {31'd0, ResultValid}, 1);
    chk("t1_error", {31'd0, Error}, 0);
    chk("t1_cycles", {16'd0, Cycles}, 5);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_acks", ack_cnt - a0, 1);
    chk("t1_ain_bin", {16'd0, Ain, Bin}, {16'd0, 8'd12, 8'd18});

    // zero operand rejected
    clr(); ld(8'd0); ld(8'd7);
    s0 = start_cnt; a0 = ack_cnt; r0 = rst_cnt;
    go();
    chk("t2_state", {25'd0, State}, {25'd0, ST_ERR});
    chk("t2_error", {31'd0, Error}, 1);
    chk("t2_busy", {31'd0, Busy}, 0);
    repeat (3) tick();
    chk("t2_starts", start_cnt - s0, 0);
    chk("t2_acks", ack_cnt - a0, 0);
    chk("t2_gcdrst", rst_cnt - r0, 0);
    ld(8'd5);
    chk("t2_err_load_state", {25'd0, State}, {25'd0, ST_LOAD_B});
    chk("t2_err_load_ain", {24'd0, Ain}, 5);

    // 255,1 -> 1 in 1+254+1+1 = 257 cycles, then rerun from SHOW
    clr(); ld(8'd255); ld(8'd1);
    go();
    wait_state(ST_SHOW, 400, "t3_show1");
    chk("t3_result1", {24'd0, Result}, 1);
    chk("t3_cycles1", {16'd0, Cycles}, 257);
    a0 = ack_cnt;
    go();
    chk("t3_rerun_state", {25'd0, State}, {25'd0, ST_RUN});
    chk("t3_rerun_cycles0", {16'd0, Cycles}, 0);
    wait_state(ST_SHOW, 400, "t3_show2");
    chk("t3_acks", ack_cnt - a0, 1);
    chk("t3_result2", {24'd0, Result}, 1);
    chk("t3_cycles2", {16'd0, Cycles}, 257);
    chk("t3_rv", {31'd0, ResultValid}, 1);

    // Clear mid-run aborts the engine
    clr(); ld(8'd48);
    chk("t4_rv_cleared", {31'd0, ResultValid}, 0);
    ld(8'd36);
    r0 = rst_cnt; a0 = ack_cnt;
    go();
    tick();
    clr();
    chk("t4_state", {25'd0, State}, {25'd0, ST_LOAD_A});
    chk("t4_gcdrst_hi", {31'd0, GcdRst}, 1);
    tick();
    chk("t4_gcdrst_lo", {31'd0, GcdRst}, 0);
    repeat (5) tick();
    chk("t4_pulses", rst_cnt - r0, 1);
    chk("t4_acks", ack_cnt - a0, 0);
    chk("t4_rv", {31'd0, ResultValid}, 0);
    chk("t4_busy", {31'd0, Busy}, 0);

    // timeout on the hung instance (TIMEOUT=20); main instance completes 9,3 -> 3
    clr(); ld(8'd9); ld(8'd3);
    r0 = t_rst_cnt;
    go();
    for (int i = 0; i < 60 && !t_Error; i++) tick();
    chk("t5_error", {31'd0, t_Error}, 1);
    chk("t5_cycles", {16'd0, t_Cycles}, 20);
    chk("t5_gcdrst_hi", {31'd0, t_GcdRst}, 1);
    chk("t5_busy", {31'd0, t_Busy}, 0);
    tick();
    chk("t5_gcdrst_lo", {31'd0, t_GcdRst}, 0);
    repeat (3) tick();
    chk("t5_pulses", t_rst_cnt - r0, 1);
    chk("t5_cycles_frozen", {16'd0, t_Cycles}, 20);
    chk("t5_main_result", {24'd0, Result}, 3);
    chk("t5_main_state", {25'd0, State}, {25'd0, ST_SHOW});

    // Load+Go together: Go wins in SHOW, Load wins in ERR
    Sw = 8'd77; Load = 1'b1; Go = 1'b1; tick(); Load = 1'b0; Go = 1'b0;
    chk("t6_show_go_wins", {25'd0, State}, {25'd0, ST_RUN});
    chk("t6_ain_kept", {24'd0, Ain}, 9);
    chk("t6_err_load_wins", {25'd0, t_State}, {25'd0, ST_LOAD_B});
    chk("t6_err_ain", {24'd0, t_Ain}, 77);
    wait_state(ST_SHOW, 50, "t6_show");
    chk("t6_result", {24'd0, Result}, 3);

`ifdef STEP_EN
    // single-step: 12,8 -> 4 in start + 2 subtracts + equal detect = 4 steps
    clr(); Step = 1'b0; tick();
    ld(8'd12); ld(8'd8);
    go();
    repeat (50) tick();
    chk("t7_idle_cycles", {16'd0, Cycles}, 0);
    chk("t7_idle_done", {31'd0, q_Done}, 0);
    chk("t7_idle_state", {25'd0, State}, {25'd0, ST_RUN});
    steps = 0;
    for (int k = 0; k < 10 && State != ST_SHOW; k++) begin
      Step = 1'b1; tick(); Step = 1'b0;
      steps++;
      repeat (3) tick();
    end
    chk("t7_state", {25'd0, State}, {25'd0, ST_SHOW});
    chk("t7_result", {24'd0, Result}, 4);
    chk("t7_cycles", {16'd0, Cycles}, steps);
    chk("t7_steps", steps, 4);
`else
    steps = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
